// File: rtl/seq_detect_prog.sv
// Programmable Moore sequence detector.
// Shifts accepted serial bits into a history register and pulses match_o one
// cycle after the bit that completes the programmed pattern. Pattern, length
// and overlap mode live in shadow registers loaded by cfg_load_i. A saturating
// match counter with a sticky saturation flag sits alongside.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b1101,
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bit_i,
  input  logic                         bit_valid_i,
  input  logic                         cfg_load_i,
  input  logic [MAX_LEN-1:0]           cfg_pattern_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len_i,
  input  logic                         cfg_overlap_i,
  input  logic                         clr_count_i,
  output logic                         match_o,
  output logic [$clog2(MAX_LEN+1)-1:0] fill_o,
  output logic [CNT_W-1:0]             count_o,
  output logic                         sat_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Length 0 behaves as 1, anything above MAX_LEN behaves as MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    res = len;
    if (len == '0) begin
      res = LEN_W'(1);
    end else if (len > LEN_W'(MAX_LEN)) begin
      res = LEN_W'(MAX_LEN);
    end
    return res;
  endfunction

  // Shadow configuration
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;

  // Only the newest MAX_LEN-1 bits are stored: together with the incoming bit
  // they form the full MAX_LEN-bit window, so the oldest shifted-out bit is
  // never needed.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] window;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   fill_inc;
  logic               match_q, match_d;

  // Match counter
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;

  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               hit;

  // Compare mask covering the active pattern length, LSB = newest bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Hit detection on the window as it will look after this cycle's bit.
  always_comb begin
    accept   = bit_valid_i && !cfg_load_i;
    window   = {hist_q, bit_i};
    fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    hit      = accept && (fill_inc == len_q) &&
               (((window ^ pat_q) & mask) == '0);
  end

  // Next-state for shadow configuration.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    if (cfg_load_i) begin
      pat_d = cfg_pattern_i;
      len_d = clamp_len(cfg_len_i);
      ovl_d = cfg_overlap_i;
    end
  end

  // Next-state for history, fill level and the match pulse.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (cfg_load_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d  = window[MAX_LEN-2:0];
      fill_d  = fill_inc;
      match_d = hit;
      // Non-overlapping mode: the matched bits may not seed the next match.
      if (hit && !ovl_q) begin
        fill_d = '0;
      end
    end
  end

  // Next-state for the saturating counter; clear wins over a coincident hit.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_count_i) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (hit && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
      if (&count_d) begin
        sat_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q   <= RST_PATTERN;
      len_q   <= clamp_len(LEN_W'(RST_LEN));
      ovl_q   <= RST_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match_o = match_q;
  assign fill_o  = fill_q;
  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog: table of vectors plus hand-written
// sequences, expectations queued at drive time and checked after each edge.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               bit_i;
  logic               bit_valid_i;
  logic               cfg_load_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LW-1:0]      cfg_len_i;
  logic               cfg_overlap_i;
  logic               clr_count_i;
  logic               match_o;
  logic [LW-1:0]      fill_o;
  logic [CNT_W-1:0]   count_o;
  logic               sat_o;

  seq_detect_prog #(
    .MAX_LEN    (MAX_LEN),
    .CNT_W      (CNT_W),
    .RST_PATTERN(8'b1101),
    .RST_LEN    (4),
    .RST_OVERLAP(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .cfg_load_i   (cfg_load_i),
    .cfg_pattern_i(cfg_pattern_i),
    .cfg_len_i    (cfg_len_i),
    .cfg_overlap_i(cfg_overlap_i),
    .clr_count_i  (clr_count_i),
    .match_o      (match_o),
    .fill_o       (fill_o),
    .count_o      (count_o),
    .sat_o        (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic       bit_v;
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       e_match;
    logic [3:0] e_fill;
    logic [1:0] e_count;
    logic       e_sat;
    string      name;
  } vec_t;

  typedef struct {
    logic       e_match;
    logic [3:0] e_fill;
    logic [1:0] e_count;
    logic       e_sat;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t V(input logic r, input logic vld, input logic b,
                             input logic ld, input logic [7:0] pat, input int len,
                             input logic ovl, input logic clr, input logic em,
                             input int ef, input int ec, input logic es,
                             input string n);
    vec_t v;
    v.rst_n = r;   v.valid = vld; v.bit_v = b;  v.load = ld;
    v.pat = pat;   v.len = 4'(len); v.ovl = ovl; v.clr = clr;
    v.e_match = em; v.e_fill = 4'(ef); v.e_count = 2'(ec); v.e_sat = es;
    v.name = n;
    return v;
  endfunction

  // Valid bit, no config activity.
  function automatic vec_t B(input logic b, input logic em, input int ef,
                             input int ec, input logic es, input string n);
    return V(1'b1, 1'b1, b, 1'b0, 8'h00, 0, 1'b0, 1'b0, em, ef, ec, es, n);
  endfunction

  // Idle cycle.
  function automatic vec_t I(input int ef, input int ec, input logic es,
                             input string n);
    return V(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, ef, ec, es, n);
  endfunction

  // Config load; history flushed, so match=0 and fill=0 afterwards.
  function automatic vec_t L(input logic [7:0] pat, input int len, input logic ovl,
                             input logic clr, input int ec, input logic es,
                             input string n);
    return V(1'b1, 1'b0, 1'b0, 1'b1, pat, len, ovl, clr, 1'b0, 0, ec, es, n);
  endfunction

  function automatic vec_t R(input string n);
    return V(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n);
  endfunction

  task automatic apply(input vec_t v);
    exp_t x;
    @(negedge clk);
    rst_n         = v.rst_n;
    bit_valid_i   = v.valid;
    bit_i         = v.bit_v;
    cfg_load_i    = v.load;
    cfg_pattern_i = v.pat;
    cfg_len_i     = v.len;
    cfg_overlap_i = v.ovl;
    clr_count_i   = v.clr;
    x.e_match = v.e_match; x.e_fill = v.e_fill;
    x.e_count = v.e_count; x.e_sat  = v.e_sat;
    x.name    = v.name;
    sb.push_back(x);
    @(posedge clk);
  endtask

  // Pop one expectation per edge and compare just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".match"}, int'(match_o), int'(e.e_match));
      chk({e.name, ".fill"},  int'(fill_o),  int'(e.e_fill));
      chk({e.name, ".count"}, int'(count_o), int'(e.e_count));
      chk({e.name, ".sat"},   int'(sat_o),   int'(e.e_sat));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; cfg_load_i = 1'b0;
    cfg_pattern_i = '0; cfg_len_i = '0; cfg_overlap_i = 1'b0; clr_count_i = 1'b0;

    // Reset, then default 1101 overlapping detector.
    tbl.push_back(R("rst0"));
    tbl.push_back(R("rst1"));
    tbl.push_back(B(1, 0, 1, 0, 0, "t1_b1"));
    tbl.push_back(B(1, 0, 2, 0, 0, "t1_b2"));
    tbl.push_back(B(0, 0, 3, 0, 0, "t1_b3"));
    tbl.push_back(B(1, 1, 4, 1, 0, "t1_b4"));
    tbl.push_back(B(1, 0, 4, 1, 0, "t1_b5"));
    tbl.push_back(B(0, 0, 4, 1, 0, "t1_b6"));
    tbl.push_back(B(1, 1, 4, 2, 0, "t1_b7"));
    tbl.push_back(I(4, 2, 0, "t1_idle"));
    // Non-overlapping 1101.
    tbl.push_back(L(8'b1101, 4, 0, 1, 0, 0, "t2_load"));
    tbl.push_back(B(1, 0, 1, 0, 0, "t2_b1"));
    tbl.push_back(B(1, 0, 2, 0, 0, "t2_b2"));
    tbl.push_back(B(0, 0, 3, 0, 0, "t2_b3"));
    tbl.push_back(B(1, 1, 0, 1, 0, "t2_b4"));
    tbl.push_back(B(1, 0, 1, 1, 0, "t2_b5"));
    tbl.push_back(B(0, 0, 2, 1, 0, "t2_b6"));
    tbl.push_back(B(1, 0, 3, 1, 0, "t2_b7"));
    // Single-bit pattern, len 1 then len 0 (clamped to 1).
    tbl.push_back(L(8'b1, 1, 1, 1, 0, 0, "t3_load1"));
    tbl.push_back(B(1, 1, 1, 1, 0, "t3a_b1"));
    tbl.push_back(B(0, 0, 1, 1, 0, "t3a_b2"));
    tbl.push_back(B(1, 1, 1, 2, 0, "t3a_b3"));
    tbl.push_back(B(1, 1, 1, 3, 1, "t3a_b4"));
    tbl.push_back(L(8'b1, 0, 1, 1, 0, 0, "t3_load0"));
    tbl.push_back(B(1, 1, 1, 1, 0, "t3b_b1"));
    tbl.push_back(B(0, 0, 1, 1, 0, "t3b_b2"));
    tbl.push_back(B(1, 1, 1, 2, 0, "t3b_b3"));
    tbl.push_back(B(1, 1, 1, 3, 1, "t3b_b4"));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Counter saturation and clear coinciding with a hit.
    apply(L(8'b1, 1, 1, 1, 0, 0, "t4_load"));
    apply(B(1, 1, 1, 1, 0, "t4_m1"));
    apply(B(1, 1, 1, 2, 0, "t4_m2"));
    apply(B(1, 1, 1, 3, 1, "t4_m3"));
    apply(B(1, 1, 1, 3, 1, "t4_m4"));
    apply(B(1, 1, 1, 3, 1, "t4_m5"));
    apply(V(1, 1, 1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, "t4_clr_hit"));
    apply(B(1, 1, 1, 1, 0, "t4_after"));
    apply(V(1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, "t4_clr_idle"));

    // Reset mid-pattern restores the default config; gaps are tolerated.
    apply(L(8'b111, 3, 0, 1, 0, 0, "t5_load"));
    apply(B(1, 0, 1, 0, 0, "t5_pre1"));
    apply(B(1, 0, 2, 0, 0, "t5_pre2"));
    apply(B(0, 0, 3, 0, 0, "t5_pre3"));
    apply(R("t5_rst"));
    apply(B(1, 0, 1, 0, 0, "t5_b1"));
    apply(B(1, 0, 2, 0, 0, "t5_b2"));
    apply(I(2, 0, 0, "t5_gap1"));
    apply(B(0, 0, 3, 0, 0, "t5_b3"));
    apply(I(3, 0, 0, "t5_gap2"));
    apply(I(3, 0, 0, "t5_gap3"));
    apply(B(1, 1, 4, 1, 0, "t5_b4"));
    apply(B(1, 0, 4, 1, 0, "t5_ovl1"));
    apply(B(0, 0, 4, 1, 0, "t5_ovl2"));
    apply(B(1, 1, 4, 2, 0, "t5_ovl3"));

    // Load with a coincident valid bit and len 9 clamped to 8.
    apply(V(1, 1, 1, 1, 8'b10110101, 9, 1, 0, 0, 0, 2, 0, "t6_load"));
    apply(B(1, 0, 1, 2, 0, "t6_b1"));
    apply(B(0, 0, 2, 2, 0, "t6_b2"));
    apply(B(1, 0, 3, 2, 0, "t6_b3"));
    apply(B(1, 0, 4, 2, 0, "t6_b4"));
    apply(B(0, 0, 5, 2, 0, "t6_b5"));
    apply(B(1, 0, 6, 2, 0, "t6_b6"));
    apply(B(0, 0, 7, 2, 0, "t6_b7"));
    apply(B(1, 1, 8, 3, 1, "t6_b8"));
    apply(B(1, 0, 8, 3, 1, "t6_b9"));

    @(negedge clk);
    bit_valid_i = 1'b0;
    cfg_load_i  = 1'b0;
    clr_count_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
